// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Brief    : Four-axis quadrature decoder. Each axis A/B pair is double
//            synchronised, optionally glitch-filtered, and decoded into a
//            wrapping signed position count with direction and a sticky
//            illegal-transition flag. One axis at a time is exposed on a
//            registered readout port.
// Macro    : QDEC_FILTER_EN - when defined, a per-axis glitch filter requires
//            FILTER_LEN identical synchronised samples before a new A/B value
//            is accepted. When undefined, s2 feeds the decoder directly.
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder #(
   parameter int CNT_W      = 8,
   parameter int FILTER_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       quad_in,
   input  logic [1:0]       axis_sel,
   input  logic             clear,
   output logic [CNT_W-1:0] pos_out,
   output logic [3:0]       dir,
   output logic [3:0]       step_err
);

   localparam int c_NUM_AXES = 4;

   // The filter counter is 4 bits wide, so the length must fit in 1..15.
   if ((FILTER_LEN < 1) || (FILTER_LEN > 15)) begin : g_bad_filter_len
      $error("quad_decoder: FILTER_LEN must be in 1..15");
   end

`ifdef QDEC_FILTER_EN
   localparam logic [3:0] c_FLEN = 4'(FILTER_LEN);
`endif

   // True when a -> b is one step along 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic is_fwd(input logic [1:0] a, input logic [1:0] b);
      return ((a == 2'b00) && (b == 2'b01)) ||
             ((a == 2'b01) && (b == 2'b11)) ||
             ((a == 2'b11) && (b == 2'b10)) ||
             ((a == 2'b10) && (b == 2'b00));
   endfunction

   logic [c_NUM_AXES*CNT_W-1:0] w_pos_all;

   for (genvar k = 0; k < c_NUM_AXES; k++) begin : g_axis
      logic [1:0]       r_s1;
      logic [1:0]       r_s2;
      logic [1:0]       r_acc;
      logic             r_primed;
      logic             r_dir;
      logic             r_err;
      logic [CNT_W-1:0] r_pos;
      logic [1:0]       w_nv;
      logic             w_new;
      logic             w_fwd;
      logic             w_rev;
      logic             w_bad;
      logic             w_clr;

      // Two-flop synchroniser for the asynchronous A/B pair.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
         end else begin
            r_s1 <= quad_in[2*k+1:2*k];
            r_s2 <= r_s1;
         end
      end

`ifdef QDEC_FILTER_EN
      logic [1:0] r_cand;
      logic [1:0] w_cand_nxt;
      logic [3:0] r_cnt;
      logic [3:0] w_cnt_nxt;

      // Next filter state: restart on any change, otherwise count up to the
      // required run length and hold there.
      always_comb begin
         w_cand_nxt = r_cand;
         w_cnt_nxt  = r_cnt;
         if (r_s2 != r_cand) begin
            w_cand_nxt = r_s2;
            w_cnt_nxt  = 4'd1;
         end else if (r_cnt < c_FLEN) begin
            w_cnt_nxt = r_cnt + 4'd1;
         end
      end

      // Filter candidate and stable-run counter registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cand <= 2'b00;
            r_cnt  <= 4'd0;
         end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
         end
      end

      // A value is presented on the edge where the run length is reached, so
      // decode looks at the filter's next state rather than its current one.
      assign w_nv  = w_cand_nxt;
      assign w_new = (w_cnt_nxt == c_FLEN) && (w_cand_nxt != r_acc);
`else
      assign w_nv  = r_s2;
      assign w_new = (r_s2 != r_acc);
`endif

      // Classify the presented value against the last accepted one; nothing
      // counts or flags until the axis has adopted its first value.
      always_comb begin
         w_fwd = w_new && r_primed && is_fwd(r_acc, w_nv);
         w_rev = w_new && r_primed && is_fwd(w_nv, r_acc);
         w_bad = w_new && r_primed && ((r_acc ^ w_nv) == 2'b11);
         w_clr = clear && (axis_sel == 2'(k));
      end

      // Accepted state, position, direction and sticky error update.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_acc    <= 2'b00;
            r_primed <= 1'b0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_err    <= 1'b0;
         end else begin
            if (w_new) begin
               r_acc    <= w_nv;
               r_primed <= 1'b1;
            end
            // Clear discards a coincident step entirely, direction included.
            if (w_clr) begin
               r_pos <= '0;
            end else if (w_fwd) begin
               r_pos <= r_pos + CNT_W'(1);
               r_dir <= 1'b1;
            end else if (w_rev) begin
               r_pos <= r_pos - CNT_W'(1);
               r_dir <= 1'b0;
            end
            // A coincident illegal jump must remain visible, so set wins.
            if (w_bad) begin
               r_err <= 1'b1;
            end else if (w_clr) begin
               r_err <= 1'b0;
            end
         end
      end

      assign w_pos_all[k*CNT_W +: CNT_W] = r_pos;
      assign dir[k]                      = r_dir;
      assign step_err[k]                 = r_err;
   end

   // Registered readout of the selected axis position.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_out <= '0;
      end else begin
         pos_out <= w_pos_all[axis_sel*CNT_W +: CNT_W];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Scoreboard bench for quad_decoder. Stimulus pushes expected
//            readout values with the cycle they are due; a monitor compares
//            them on the falling edge. Adapts to QDEC_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_quad_decoder;

   localparam int CNT_W      = 8;
   localparam int FILTER_LEN = 2;
`ifdef QDEC_FILTER_EN
   localparam int LAT_ACC = 1 + FILTER_LEN;
   localparam bit FILT    = 1'b1;
`else
   localparam int LAT_ACC = 2;
   localparam bit FILT    = 1'b0;
`endif
   localparam int LAT_OUT = LAT_ACC + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       quad_in;
   logic [1:0]       axis_sel;
   logic             clear;
   logic [CNT_W-1:0] pos_out;
   logic [3:0]       dir;
   logic [3:0]       step_err;

   quad_decoder #(.CNT_W(CNT_W), .FILTER_LEN(FILTER_LEN)) dut (
      .clk      (clk),
      .reset    (reset),
      .quad_in  (quad_in),
      .axis_sel (axis_sel),
      .clear    (clear),
      .pos_out  (pos_out),
      .dir      (dir),
      .step_err (step_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [7:0] pos;
      logic [3:0] dr;
      logic [3:0] er;
      bit         pos_only;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   flush  = 1'b0;

   // Monitor: compare every entry whose due cycle has arrived.
   always @(negedge clk) begin
      while (q.size() > 0 && (flush || q[0].due <= cyc)) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (flush) begin
            errors++;
            $display("FAIL %s: never compared (timeout), want pos_out=%h", e.name, e.pos);
         end else if (pos_out !== e.pos ||
                      (!e.pos_only && (dir !== e.dr || step_err !== e.er))) begin
            errors++;
            $display("FAIL %s: got pos_out=%h dir=%b step_err=%b, want pos_out=%h dir=%b step_err=%b",
                     e.name, pos_out, dir, step_err, e.pos, e.dr, e.er);
         end
      end
   end

   task automatic push_exp(input int due, input logic [7:0] p, input logic [3:0] d,
                           input logic [3:0] e, input bit po, input string nm);
      exp_t x;
      x.due = due; x.pos = p; x.dr = d; x.er = e; x.pos_only = po; x.name = nm;
      q.push_back(x);
   endtask

   task automatic expect_now(input string nm, input logic [7:0] p,
                             input logic [3:0] d, input logic [3:0] e);
      push_exp(cyc, p, d, e, 1'b0, nm);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_axis(input int k, input logic [1:0] v);
      quad_in[2*k +: 2] = v;
   endtask

   task automatic step(input int k, input logic [1:0] v, input int hold);
      set_axis(k, v);
      tick(hold);
   endtask

   task automatic settle();
      tick(6);
   endtask

   task automatic do_reset();
      reset = 1'b1; clear = 1'b0; quad_in = 8'h00;
      tick(2);
      reset = 1'b0;
   endtask

   function automatic logic [1:0] nxt(input logic [1:0] g);
      case (g)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] prv(input logic [1:0] g);
      case (g)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   initial begin
      logic [1:0] g;
      reset = 1'b1; quad_in = 8'h00; axis_sel = 2'd0; clear = 1'b0;
      tick(3);
      expect_now("reset", 8'h00, 4'b0000, 4'b0000);

      // Silent prime of all axes to 11.
      reset = 1'b0; quad_in = 8'hFF;
      tick(10);
      expect_now("prime_ff", 8'h00, 4'b0000, 4'b0000);

      // Axis 0 forward four steps with exact readout latency on the first.
      do_reset(); axis_sel = 2'd0;
      step(0, 2'b01, 4);
      expect_now("a0_prime", 8'h00, 4'b0000, 4'b0000);
      set_axis(0, 2'b11);
      push_exp(cyc + LAT_OUT,     8'h00, 4'b0000, 4'b0000, 1'b1, "a0_lat_before");
      push_exp(cyc + LAT_OUT + 1, 8'h01, 4'b0000, 4'b0000, 1'b1, "a0_lat_after");
      tick(4);
      step(0, 2'b10, 4);
      step(0, 2'b00, 4);
      step(0, 2'b01, 4);
      settle();
      expect_now("a0_fwd", 8'h04, 4'b0001, 4'b0000);
      step(0, 2'b00, 4);
      settle();
      expect_now("a0_rev1", 8'h03, 4'b0000, 4'b0000);
      step(0, 2'b10, 4);
      step(0, 2'b11, 4);
      step(0, 2'b01, 4);
      settle();
      expect_now("a0_rev", 8'h00, 4'b0000, 4'b0000);

      // Axis 1: count, illegal jump, then clear.
      step(0, 2'b11, 4);
      settle();
      do_reset();
      expect_now("mid_reset", 8'h00, 4'b0000, 4'b0000);
      axis_sel = 2'd1;
      step(1, 2'b01, 4);
      step(1, 2'b11, 4);
      step(1, 2'b10, 4);
      settle();
      expect_now("a1_fwd2", 8'h02, 4'b0010, 4'b0000);
      step(1, 2'b01, 4);
      settle();
      expect_now("a1_illegal", 8'h02, 4'b0010, 4'b0010);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      expect_now("a1_clr_err", 8'h02, 4'b0010, 4'b0000);
      tick(1);
      expect_now("a1_clr_pos", 8'h00, 4'b0010, 4'b0000);

      // Axis 2 wrap-around.
      do_reset(); axis_sel = 2'd2;
      g = 2'b01;
      step(2, g, 4);
      for (int i = 0; i < 127; i++) begin
         g = nxt(g);
         step(2, g, 4);
      end
      settle();
      expect_now("a2_127", 8'h7F, 4'b0100, 4'b0000);
      g = nxt(g);
      step(2, g, 4);
      settle();
      expect_now("a2_128", 8'h80, 4'b0100, 4'b0000);
      g = prv(g);
      step(2, g, 4);
      settle();
      expect_now("a2_rev", 8'h7F, 4'b0000, 4'b0000);
      g = nxt(g);
      step(2, g, 4);
      settle();
      expect_now("a2_fwd", 8'h80, 4'b0100, 4'b0000);

      // Axis 3 one-cycle glitch.
      do_reset(); axis_sel = 2'd3;
      step(3, 2'b10, 4);
      step(3, 2'b00, 4);
      settle();
      expect_now("a3_step", 8'h01, 4'b1000, 4'b0000);
      set_axis(3, 2'b01);
      tick(1);
      set_axis(3, 2'b00);
      settle();
      expect_now("a3_glitch", 8'h01, FILT ? 4'b1000 : 4'b0000, 4'b0000);

      // Step coinciding with clear on the selected axis is lost.
      do_reset(); axis_sel = 2'd0;
      step(0, 2'b01, 4);
      step(0, 2'b11, 4);
      settle();
      expect_now("col_pre", 8'h01, 4'b0001, 4'b0000);
      set_axis(0, 2'b10);
      tick(LAT_ACC);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      settle();
      expect_now("col_lost", 8'h00, 4'b0001, 4'b0000);
      step(0, 2'b00, 4);
      settle();
      expect_now("col_next", 8'h01, 4'b0001, 4'b0000);

      // Simultaneous steps on all axes, read back through axis_sel.
      do_reset();
      quad_in = 8'h55;
      settle();
      quad_in = 8'hFF;
      settle();
      for (int k = 0; k < 4; k++) begin
         axis_sel = 2'(k);
         tick(1);
         expect_now($sformatf("all_ax%0d", k), 8'h01, 4'b1111, 4'b0000);
      end

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
